// File: rtl/mouse_move_ctrl.sv
// mouse_move_ctrl: turns local mouse clicks into board-move transactions.
//   Click 1 selects a source block, click 2 selects a destination and raises
//   move_req, which is held until the game logic acks, nacks or times out.
//   Cheat pulses are serialised into the same stream and served only in IDLE.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   l_click, cheat_activate       one-cycle mouse / cheat pulses
//   mouse_inblock, mouse_block_x/y cursor position in block coordinates
//   my_turn                       local player may move
//   move_ack, move_nack           one-cycle game-logic responses
//   sel_valid, src_x/y, dst_x/y   selection highlight and latched blocks
//   move_req                      level request, held until resolved
//   cheat_req, move_done, move_err, sel_timeout  one-cycle registered pulses
//   move_count                    accepted moves, saturating at 255
module mouse_move_ctrl #(
    parameter int unsigned SEL_TIMEOUT = 100_000_000,
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned TW          = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       l_click,
    input  logic       cheat_activate,
    input  logic       mouse_inblock,
    input  logic [4:0] mouse_block_x,
    input  logic [2:0] mouse_block_y,
    input  logic       my_turn,
    input  logic       move_ack,
    input  logic       move_nack,
    output logic       sel_valid,
    output logic [4:0] src_x,
    output logic [2:0] src_y,
    output logic [4:0] dst_x,
    output logic [2:0] dst_y,
    output logic       move_req,
    output logic       cheat_req,
    output logic       move_done,
    output logic       move_err,
    output logic       sel_timeout,
    output logic [7:0] move_count
);

    localparam int unsigned XW = 5;
    localparam int unsigned YW = 3;
    localparam int unsigned CW = 8;

    // Terminal timer values: the timer starts at 0 on entry to a state.
    localparam logic [TW-1:0] SEL_LAST = TW'(SEL_TIMEOUT - 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SRC_HELD = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic          cheat_pend, cheat_pend_d;

    logic          sel_valid_d;
    logic [XW-1:0] src_x_d, dst_x_d;
    logic [YW-1:0] src_y_d, dst_y_d;
    logic          move_req_d;
    logic          cheat_req_d;
    logic          move_done_d;
    logic          move_err_d;
    logic          sel_timeout_d;
    logic [CW-1:0] move_count_d;

    logic          valid_click_c;
    logic          same_block_c;

    assign valid_click_c = l_click & mouse_inblock;
    assign same_block_c  = (mouse_block_x == src_x) && (mouse_block_y == src_y);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            cheat_pend  <= 1'b0;
            sel_valid   <= 1'b0;
            src_x       <= '0;
            src_y       <= '0;
            dst_x       <= '0;
            dst_y       <= '0;
            move_req    <= 1'b0;
            cheat_req   <= 1'b0;
            move_done   <= 1'b0;
            move_err    <= 1'b0;
            sel_timeout <= 1'b0;
            move_count  <= '0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            cheat_pend  <= cheat_pend_d;
            sel_valid   <= sel_valid_d;
            src_x       <= src_x_d;
            src_y       <= src_y_d;
            dst_x       <= dst_x_d;
            dst_y       <= dst_y_d;
            move_req    <= move_req_d;
            cheat_req   <= cheat_req_d;
            move_done   <= move_done_d;
            move_err    <= move_err_d;
            sel_timeout <= sel_timeout_d;
            move_count  <= move_count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        timer_d       = timer + TW'(1);
        cheat_pend_d  = cheat_pend;
        sel_valid_d   = sel_valid;
        src_x_d       = src_x;
        src_y_d       = src_y;
        dst_x_d       = dst_x;
        dst_y_d       = dst_y;
        move_req_d    = move_req;
        cheat_req_d   = 1'b0;
        move_done_d   = 1'b0;
        move_err_d    = 1'b0;
        sel_timeout_d = 1'b0;
        move_count_d  = move_count;

        case (state)
            IDLE: begin
                timer_d = '0;
                // A cheat (fresh or deferred) wins and drops a same-cycle click.
                if (cheat_pend || cheat_activate) begin
                    cheat_req_d  = 1'b1;
                    cheat_pend_d = 1'b0;
                end else if (valid_click_c && my_turn) begin
                    src_x_d     = mouse_block_x;
                    src_y_d     = mouse_block_y;
                    sel_valid_d = 1'b1;
                    state_d     = SRC_HELD;
                end
            end

            SRC_HELD: begin
                if (cheat_activate) begin
                    cheat_pend_d = 1'b1;
                end
                if (!my_turn) begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    timer_d     = '0;
                end else if (valid_click_c) begin
                    if (same_block_c) begin
                        state_d     = IDLE;
                        sel_valid_d = 1'b0;
                        timer_d     = '0;
                    end else begin
                        dst_x_d    = mouse_block_x;
                        dst_y_d    = mouse_block_y;
                        move_req_d = 1'b1;
                        timer_d    = '0;
                        state_d    = WAIT_ACK;
                    end
                end else if (l_click) begin
                    // Click outside the board cancels the selection.
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    timer_d     = '0;
                end else if (timer == SEL_LAST) begin
                    sel_timeout_d = 1'b1;
                    state_d       = IDLE;
                    sel_valid_d   = 1'b0;
                    timer_d       = '0;
                end
            end

            WAIT_ACK: begin
                if (cheat_activate) begin
                    cheat_pend_d = 1'b1;
                end
                // nack dominates a simultaneous ack.
                if (move_nack) begin
                    move_err_d  = 1'b1;
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    move_req_d  = 1'b0;
                    timer_d     = '0;
                end else if (move_ack) begin
                    move_done_d = 1'b1;
                    if (move_count != CNT_MAX) begin
                        move_count_d = move_count + CW'(1);
                    end
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    move_req_d  = 1'b0;
                    timer_d     = '0;
                end else if (timer == ACK_LAST) begin
                    move_err_d  = 1'b1;
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    move_req_d  = 1'b0;
                    timer_d     = '0;
                end
            end

            default: begin
                state_d     = IDLE;
                sel_valid_d = 1'b0;
                move_req_d  = 1'b0;
                timer_d     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mouse_move_ctrl.sv
// Directed bench for mouse_move_ctrl with short timeouts (SEL 16, ACK 8).
module tb_mouse_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       l_click;
    logic       cheat_activate;
    logic       mouse_inblock;
    logic [4:0] mouse_block_x;
    logic [2:0] mouse_block_y;
    logic       my_turn;
    logic       move_ack;
    logic       move_nack;
    logic       sel_valid;
    logic [4:0] src_x;
    logic [2:0] src_y;
    logic [4:0] dst_x;
    logic [2:0] dst_y;
    logic       move_req;
    logic       cheat_req;
    logic       move_done;
    logic       move_err;
    logic       sel_timeout;
    logic [7:0] move_count;

    int errors = 0;
    int checks = 0;

    mouse_move_ctrl #(
        .SEL_TIMEOUT(16),
        .ACK_TIMEOUT(8),
        .TW(27)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .l_click        (l_click),
        .cheat_activate (cheat_activate),
        .mouse_inblock  (mouse_inblock),
        .mouse_block_x  (mouse_block_x),
        .mouse_block_y  (mouse_block_y),
        .my_turn        (my_turn),
        .move_ack       (move_ack),
        .move_nack      (move_nack),
        .sel_valid      (sel_valid),
        .src_x          (src_x),
        .src_y          (src_y),
        .dst_x          (dst_x),
        .dst_y          (dst_y),
        .move_req       (move_req),
        .cheat_req      (cheat_req),
        .move_done      (move_done),
        .move_err       (move_err),
        .sel_timeout    (sel_timeout),
        .move_count     (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic click(input logic [4:0] x, input logic [2:0] y, input logic inb);
        @(negedge clk);
        l_click       = 1'b1;
        mouse_block_x = x;
        mouse_block_y = y;
        mouse_inblock = inb;
        @(negedge clk);
        l_click       = 1'b0;
        mouse_inblock = 1'b0;
    endtask

    task automatic respond(input logic ack, input logic nack);
        @(negedge clk);
        move_ack  = ack;
        move_nack = nack;
        @(negedge clk);
        move_ack  = 1'b0;
        move_nack = 1'b0;
    endtask

    task automatic cheat_pulse();
        @(negedge clk);
        cheat_activate = 1'b1;
        @(negedge clk);
        cheat_activate = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({sel_valid, move_req, cheat_req, move_done, move_err, sel_timeout} !== 6'b0 ||
            move_count !== 8'd0 || src_x !== 5'd0 || dst_y !== 3'd0) begin
            errors++;
            $display("FAIL reset: sel=%b req=%b cnt=%0d src_x=%0d, expected all zero",
                     sel_valid, move_req, move_count, src_x);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic_move();
        my_turn = 1'b1;
        click(5'd3, 3'd2, 1'b1);
        checks++;
        if (sel_valid !== 1'b1 || src_x !== 5'd3 || src_y !== 3'd2) begin
            errors++;
            $display("FAIL select_src: sel=%b src=(%0d,%0d), expected 1 (3,2)", sel_valid, src_x, src_y);
        end
        click(5'd7, 3'd4, 1'b1);
        checks++;
        if (move_req !== 1'b1 || sel_valid !== 1'b1 || dst_x !== 5'd7 || dst_y !== 3'd4) begin
            errors++;
            $display("FAIL move_req: req=%b sel=%b dst=(%0d,%0d), expected 1 1 (7,4)",
                     move_req, sel_valid, dst_x, dst_y);
        end
        step(4);
        respond(1'b1, 1'b0);
        checks++;
        if (move_done !== 1'b1 || move_count !== 8'd1 || move_req !== 1'b0 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack: done=%b cnt=%0d req=%b sel=%b, expected 1 1 0 0",
                     move_done, move_count, move_req, sel_valid);
        end
        step(1);
        checks++;
        if (move_done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b, expected 0", move_done);
        end
    endtask

    task automatic test_deselect_cancel();
        click(5'd3, 3'd2, 1'b1);
        click(5'd3, 3'd2, 1'b1);
        checks++;
        if (sel_valid !== 1'b0 || move_req !== 1'b0) begin
            errors++;
            $display("FAIL deselect: sel=%b req=%b, expected 0 0", sel_valid, move_req);
        end
        click(5'd3, 3'd2, 1'b1);
        click(5'd9, 3'd1, 1'b0);
        checks++;
        if (sel_valid !== 1'b0 || move_req !== 1'b0) begin
            errors++;
            $display("FAIL outside_cancel: sel=%b req=%b, expected 0 0", sel_valid, move_req);
        end
        click(5'd2, 3'd2, 1'b1);
        @(negedge clk);
        my_turn = 1'b0;
        @(negedge clk);
        my_turn = 1'b1;
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL turn_drop: sel=%b, expected 0", sel_valid);
        end
        respond(1'b1, 1'b0);
        checks++;
        if (move_done !== 1'b0 || move_count !== 8'd1) begin
            errors++;
            $display("FAIL idle_ack: done=%b cnt=%0d, expected 0 1", move_done, move_count);
        end
    endtask

    task automatic test_sel_timeout();
        click(5'd1, 3'd1, 1'b1);
        step(15);
        checks++;
        if (sel_valid !== 1'b1 || sel_timeout !== 1'b0) begin
            errors++;
            $display("FAIL sel_early: sel=%b to=%b, expected 1 0", sel_valid, sel_timeout);
        end
        step(1);
        checks++;
        if (sel_timeout !== 1'b1 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_timeout: to=%b sel=%b, expected 1 0", sel_timeout, sel_valid);
        end
        step(1);
        checks++;
        if (sel_timeout !== 1'b0) begin
            errors++;
            $display("FAIL sel_to_width: to=%b, expected 0", sel_timeout);
        end
    endtask

    task automatic test_ack_timeout();
        click(5'd1, 3'd1, 1'b1);
        click(5'd2, 3'd2, 1'b1);
        step(7);
        checks++;
        if (move_req !== 1'b1 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_early: req=%b err=%b, expected 1 0", move_req, move_err);
        end
        step(1);
        checks++;
        if (move_err !== 1'b1 || move_req !== 1'b0 || move_count !== 8'd1) begin
            errors++;
            $display("FAIL ack_timeout: err=%b req=%b cnt=%0d, expected 1 0 1",
                     move_err, move_req, move_count);
        end
        click(5'd1, 3'd1, 1'b1);
        click(5'd2, 3'd2, 1'b1);
        click(5'd5, 3'd5, 1'b1);
        checks++;
        if (move_req !== 1'b1 || dst_x !== 5'd2 || dst_y !== 3'd2) begin
            errors++;
            $display("FAIL wait_click_ignored: req=%b dst=(%0d,%0d), expected 1 (2,2)",
                     move_req, dst_x, dst_y);
        end
        respond(1'b1, 1'b1);
        checks++;
        if (move_err !== 1'b1 || move_done !== 1'b0 || move_count !== 8'd1 || move_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_nack: err=%b done=%b cnt=%0d req=%b, expected 1 0 1 0",
                     move_err, move_done, move_count, move_req);
        end
    endtask

    task automatic test_cheat();
        click(5'd1, 3'd1, 1'b1);
        click(5'd4, 3'd3, 1'b1);
        cheat_pulse();
        cheat_pulse();
        step(2);
        checks++;
        if (cheat_req !== 1'b0 || move_req !== 1'b1) begin
            errors++;
            $display("FAIL cheat_deferred: cheat=%b req=%b, expected 0 1", cheat_req, move_req);
        end
        respond(1'b1, 1'b0);
        checks++;
        if (move_done !== 1'b1 || cheat_req !== 1'b0 || move_count !== 8'd2) begin
            errors++;
            $display("FAIL cheat_ack: done=%b cheat=%b cnt=%0d, expected 1 0 2",
                     move_done, cheat_req, move_count);
        end
        step(1);
        checks++;
        if (cheat_req !== 1'b1) begin
            errors++;
            $display("FAIL cheat_served: cheat=%b, expected 1", cheat_req);
        end
        step(2);
        checks++;
        if (cheat_req !== 1'b0) begin
            errors++;
            $display("FAIL cheat_collapse: cheat=%b, expected 0", cheat_req);
        end
        @(negedge clk);
        cheat_activate = 1'b1;
        l_click        = 1'b1;
        mouse_inblock  = 1'b1;
        mouse_block_x  = 5'd6;
        mouse_block_y  = 3'd1;
        @(negedge clk);
        cheat_activate = 1'b0;
        l_click        = 1'b0;
        mouse_inblock  = 1'b0;
        checks++;
        if (cheat_req !== 1'b1 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL cheat_vs_click: cheat=%b sel=%b, expected 1 0", cheat_req, sel_valid);
        end
        step(1);
        checks++;
        if (cheat_req !== 1'b0 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL cheat_after: cheat=%b sel=%b, expected 0 0", cheat_req, sel_valid);
        end
    endtask

    task automatic test_async_reset();
        click(5'd1, 3'd1, 1'b1);
        click(5'd2, 3'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (move_req !== 1'b0 || sel_valid !== 1'b0 || move_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: req=%b sel=%b cnt=%0d, expected 0 0 0",
                     move_req, sel_valid, move_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            click(5'd1, 3'd1, 1'b1);
            click(5'd2, 3'd2, 1'b1);
            respond(1'b1, 1'b0);
            if (i == 0) begin
                checks++;
                if (move_count !== 8'd1) begin
                    errors++;
                    $display("FAIL sat_first: cnt=%0d, expected 1", move_count);
                end
            end
        end
        checks++;
        if (move_count !== 8'd255 || move_done !== 1'b1) begin
            errors++;
            $display("FAIL saturate: cnt=%0d done=%b, expected 255 1", move_count, move_done);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        l_click        = 1'b0;
        cheat_activate = 1'b0;
        mouse_inblock  = 1'b0;
        mouse_block_x  = 5'd0;
        mouse_block_y  = 3'd0;
        my_turn        = 1'b0;
        move_ack       = 1'b0;
        move_nack      = 1'b0;

        test_reset();
        test_basic_move();
        test_deselect_cancel();
        test_sel_timeout();
        test_ack_timeout();
        test_cheat();
        test_async_reset();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
